// File: rtl/instr_fetch_unit_pkg.sv
// Shared RISC-V types plus fetch-unit local types.
// riscv_pkg is also imported by decode; instr_fetch_unit_pkg holds fetch-only items.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

package instr_fetch_unit_pkg;
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } ifu_state_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the fetch unit: PC stream in, ROM port, decode stream out.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 10
);
  import riscv_pkg::*;

  logic [XLEN-1:0]   fetch_addr;
  logic              fetch_valid;
  logic              fetch_ready;
  logic              jump;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   imem_rdata;
  logic [XLEN-1:0]   instr;
  logic [XLEN-1:0]   instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              misalign_err;

  // slave = the fetch unit; master = PC/ROM/decoder environment
  modport slave (
    input  fetch_addr, fetch_valid, jump, imem_rdata, instr_ready,
    output fetch_ready, imem_req, imem_addr, instr, instr_pc, instr_valid, misalign_err
  );

  modport master (
    output fetch_addr, fetch_valid, jump, imem_rdata, instr_ready,
    input  fetch_ready, imem_req, imem_addr, instr, instr_pc, instr_valid, misalign_err
  );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO with clear; pop on empty ignored, push on full (without pop) ignored.
module sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_rdata   = r_mem[r_rd];
  assign o_count   = r_count;

  // pointers are AW bits and DEPTH is a power of two, so wrap is free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr] <= i_wdata;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC stream -> 1-cycle sync ROM read -> {pc,instr} queue for decode.
// jump flushes the queue and the read in flight.
module instr_fetch_unit
  import riscv_pkg::*;
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input logic              clk,
  input logic              reset,
  instr_fetch_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_t      r_state;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_misalign;

  logic            w_inflight;
  logic [CW:0]     w_occ;
  logic            w_ready;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  logic            w_empty;
  fetch_entry_t    w_wentry;
  fetch_entry_t    w_head;

  assign w_inflight = (r_state == S_WAIT);
  // reserving a slot for the in-flight read means a response always finds room
  assign w_occ      = (CW+1)'(w_count) + (CW+1)'(w_inflight);
  assign w_ready    = ~reset & (w_occ < (CW+1)'(DEPTH));
  assign w_accept   = bus.fetch_valid & w_ready & ~bus.jump;
  assign w_push     = w_inflight & ~bus.jump;
  assign w_pop      = ~w_empty & bus.instr_ready & ~bus.jump;
  assign w_wentry   = '{pc: r_inflight_pc, instr: bus.imem_rdata};

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (bus.jump),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_inflight_pc <= '0;
      r_misalign    <= 1'b0;
    end else begin
      if (bus.jump)      r_state <= S_IDLE;
      else if (w_accept) r_state <= S_WAIT;
      else               r_state <= S_IDLE;
      if (w_accept) begin
        r_inflight_pc <= bus.fetch_addr;
        if (is_misaligned(bus.fetch_addr[1:0])) r_misalign <= 1'b1;
      end
    end
  end

  assign bus.fetch_ready  = w_ready;
  assign bus.imem_req     = w_accept;
  assign bus.imem_addr    = w_accept ? bus.fetch_addr[ADDR_W+1:2] : '0;
  assign bus.instr_valid  = ~w_empty;
  assign bus.instr        = w_empty ? NOP : w_head.instr;
  assign bus.instr_pc     = w_empty ? '0  : w_head.pc;
  assign bus.misalign_err = r_misalign;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected {pc,instr}, monitor pops on handshake.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  fetch_entry_t exp_q[$];

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(10)) bus();

  instr_fetch_unit #(.DEPTH(4), .ADDR_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ROM preload: word i = 0x1000_0000 + i
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= 32'h1000_0000 + 32'(bus.imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: a consumed head must match the oldest expected entry
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!reset && !bus.jump && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got pc %h instr %h expected none", bus.instr_pc, bus.instr);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", bus.instr_pc, e.pc);
        chk("pop_instr", bus.instr, e.instr);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // offer addr until accepted; leaves fetch_valid high so calls stream back-to-back
  task automatic fetch(input logic [31:0] a, input logic [31:0] ins);
    bus.fetch_addr  = a;
    bus.fetch_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.fetch_ready) begin
        exp_q.push_back('{pc: a, instr: ins});
        cyc();
        return;
      end
      cyc();
    end
    checks++;
    failures++;
    $display("FAIL fetch_timeout: got no accept for %h expected accept", a);
    bus.fetch_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) begin
        checks++;
        return;
      end
      cyc();
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
    exp_q.delete();
  endtask

  logic [31:0] t1_max;
  logic        t1_on = 1'b0;
  always @(negedge clk) if (t1_on && 32'(dut.w_count) > t1_max) t1_max = 32'(dut.w_count);

  initial begin
    int n;
    reset = 1'b1;
    bus.fetch_addr  = '0;
    bus.fetch_valid = 1'b0;
    bus.jump        = 1'b0;
    bus.instr_ready = 1'b0;
    bus.imem_rdata  = '0;
    t1_max = '0;
    cyc();
    cyc();
    chk("rst_instr_valid", 32'(bus.instr_valid), 0);
    chk("rst_instr", bus.instr, 32'h0000_0013);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_imem_req", 32'(bus.imem_req), 0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 0);
    chk("rst_misalign", 32'(bus.misalign_err), 0);
    reset = 1'b0;
    #1;
    chk("rst_fetch_ready", 32'(bus.fetch_ready), 1);
    cyc();

    // 1: streaming with decoder always ready; first word visible 2 cycles after accept
    bus.instr_ready = 1'b1;
    t1_on = 1'b1;
    fetch(32'h0, 32'h1000_0000);
    chk("t1_lat_cycle1", 32'(bus.instr_valid), 0);
    fetch(32'h4, 32'h1000_0001);
    chk("t1_lat_cycle2", 32'(bus.instr_valid), 1);
    fetch(32'h8, 32'h1000_0002);
    fetch(32'hC, 32'h1000_0003);
    bus.fetch_valid = 1'b0;
    wait_drain();
    t1_on = 1'b0;
    chk("t1_count_le2", 32'(t1_max <= 2), 1);

    // 2: back-pressure: exactly 4 accepts then fetch_ready low
    bus.instr_ready = 1'b0;
    bus.fetch_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      bus.fetch_addr = 32'(4 * n);
      @(negedge clk);
      if (bus.fetch_ready) begin
        exp_q.push_back('{pc: 32'(4 * n), instr: 32'h1000_0000 + 32'(n)});
        n++;
      end
      cyc();
    end
    chk("t2_accepts", 32'(n), 4);
    chk("t2_fetch_ready", 32'(bus.fetch_ready), 0);
    chk("t2_count", 32'(dut.w_count), 4);
    bus.fetch_valid = 1'b0;
    bus.instr_ready = 1'b1;
    wait_drain();
    cyc();

    // 3: jump with 2 queued and addr 8 in flight; offer during jump must be ignored
    bus.instr_ready = 1'b0;
    fetch(32'h0, 32'h1000_0000);
    fetch(32'h4, 32'h1000_0001);
    fetch(32'h8, 32'h1000_0002);
    chk("t3_pre_count", 32'(dut.w_count), 2);
    bus.fetch_addr = 32'h80;
    bus.jump = 1'b1;
    exp_q.delete();
    cyc();
    bus.jump = 1'b0;
    bus.fetch_valid = 1'b0;
    chk("t3_valid_after_jump", 32'(bus.instr_valid), 0);
    cyc();
    chk("t3_still_empty", 32'(bus.instr_valid), 0);
    bus.instr_ready = 1'b1;
    fetch(32'h40, 32'h1000_0010);
    bus.fetch_valid = 1'b0;
    wait_drain();
    repeat (4) cyc();

    // 4: push and pop together at count 2 across pointer wrap
    bus.instr_ready = 1'b0;
    fetch(32'h0, 32'h1000_0000);
    fetch(32'h4, 32'h1000_0001);
    fetch(32'h8, 32'h1000_0002);
    bus.instr_ready = 1'b1;
    for (int i = 3; i < 13; i++) begin
      fetch(32'(4 * i), 32'h1000_0000 + 32'(i));
      chk("t4_count", 32'(dut.w_count), 2);
    end
    bus.fetch_valid = 1'b0;
    wait_drain();
    cyc();

    // 5: asynchronous reset between edges mid-stream
    bus.instr_ready = 1'b0;
    fetch(32'h2, 32'h1000_0000);
    fetch(32'h8, 32'h1000_0002);
    chk("t5_misalign_set", 32'(bus.misalign_err), 1);
    bus.fetch_addr = 32'hC;
    #2;
    reset = 1'b1;
    #1;
    chk("t5_instr_valid", 32'(bus.instr_valid), 0);
    chk("t5_instr", bus.instr, 32'h0000_0013);
    chk("t5_instr_pc", bus.instr_pc, 0);
    chk("t5_imem_req", 32'(bus.imem_req), 0);
    chk("t5_imem_addr", 32'(bus.imem_addr), 0);
    chk("t5_misalign", 32'(bus.misalign_err), 0);
    exp_q.delete();
    bus.fetch_valid = 1'b0;
    cyc();
    reset = 1'b0;
    #1;
    chk("t5_fetch_ready", 32'(bus.fetch_ready), 1);
    cyc();

    // 6: misaligned fetch reads truncated word and sets sticky flag
    bus.instr_ready = 1'b1;
    bus.fetch_addr  = 32'h6;
    bus.fetch_valid = 1'b1;
    @(negedge clk);
    chk("t6_imem_req", 32'(bus.imem_req), 1);
    chk("t6_imem_addr", 32'(bus.imem_addr), 1);
    exp_q.push_back('{pc: 32'h6, instr: 32'h1000_0001});
    cyc();
    chk("t6_misalign", 32'(bus.misalign_err), 1);
    fetch(32'h10, 32'h1000_0004);
    fetch(32'h14, 32'h1000_0005);
    bus.fetch_valid = 1'b0;
    wait_drain();
    chk("t6_misalign_held", 32'(bus.misalign_err), 1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
